ex_seq_multiplier: RTL

//  Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU in the EX stage.

---
 rtl/ex_seq_multiplier.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ex_seq_multiplier.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU (EX stage).
// Optional MUL_EARLY_EXIT_EN: leave CALC once the remaining multiplier bits are all zero.
module ex_seq_multiplier #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW     = $clog2(XLEN + 1);
  localparam int NSLICE = XLEN / 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CW-1:0]     CNT_ONE  = 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0]   ONE      = 1;
  localparam logic [2*XLEN-1:0] ONE2     = 1;

  logic [1:0]        r_state;
  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_mult;
  logic [2*XLEN-1:0] r_acc;
  logic              r_neg;
  logic [CW-1:0]     r_count;
  logic [XLEN-1:0]   r_result;

  logic              w_neg1, w_neg2;
  logic [XLEN-1:0]   w_mag1, w_mag2;
  logic              w_accept;
  logic [XLEN-1:0]   w_addend;
  logic [XLEN-1:0]   w_sum;
  logic [NSLICE:0]   w_carry;
  logic [2*XLEN-1:0] w_acc_next;
  logic [XLEN-1:0]   w_mult_next;
  logic              w_last;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fixed;

  // rs1 is signed unless MULHU; rs2 is signed only for MUL/MULH.
  assign w_neg1 = (op != 2'b11) && rs1[XLEN-1];
  assign w_neg2 = !op[1] && rs2[XLEN-1];
  assign w_mag1 = w_neg1 ? (~rs1 + ONE) : rs1;
  assign w_mag2 = w_neg2 ? (~rs2 + ONE) : rs2;

  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && start && !flush;

  // Accumulate adder: 4-bit carry-lookahead slices, ripple between slices.
  assign w_addend   = r_mult[0] ? r_mcand : '0;
  assign w_carry[0] = 1'b0;

  for (genvar s = 0; s < NSLICE; s++) begin : g_cla
    logic [3:0] w_a, w_b, w_p, w_g, w_c;
    assign w_a    = r_acc[XLEN + 4*s +: 4];
    assign w_b    = w_addend[4*s +: 4];
    assign w_p    = w_a ^ w_b;
    assign w_g    = w_a & w_b;
    assign w_c[0] = w_carry[s];
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_carry[s+1] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                        | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                        | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_sum[4*s +: 4] = w_p ^ w_c;
  end

  // Top-slice carry-out becomes the new MSB, so no product bit is lost on the shift.
  assign w_acc_next  = {w_carry[NSLICE], w_sum, r_acc[XLEN-1:1]};
  assign w_mult_next = r_mult >> 1;

`ifdef MUL_EARLY_EXIT_EN
  assign w_last = (r_count == CNT_LAST) || (w_mult_next == '0);
  // Remaining iterations would only shift zeros in; do them all at once.
  assign w_prod = r_acc >> (CW'(XLEN) - r_count);
`else
  assign w_last = (r_count == CNT_LAST);
  assign w_prod = r_acc;
`endif

  assign w_prod_fixed = r_neg ? (~w_prod + ONE2) : w_prod;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_mcand  <= '0;
      r_mult   <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_CALC: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_acc   <= w_acc_next;
            r_mult  <= w_mult_next;
            r_count <= r_count + CNT_ONE;
            if (w_last) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_result <= (r_op == 2'b00) ? w_prod_fixed[XLEN-1:0] : w_prod_fixed[2*XLEN-1:XLEN];
            r_state  <= S_DONE;
          end
        end
        default: begin
          if (w_accept) begin
            r_op    <= op;
            r_mcand <= w_mag1;
            r_mult  <= w_mag2;
            r_acc   <= '0;
            r_neg   <= w_neg1 ^ w_neg2;
            r_count <= '0;
            r_state <= S_CALC;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy   = (r_state == S_CALC) || (r_state == S_FIX);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule
